lab9_soc_sysid_regs: RTL and testbench

Parametrised system-identification register bank for the lab9 SoC, sitting on the Avalon-MM interconnect as a read-mostly slave next to the CPU. Extends the fixed single-word ID/timestamp slave with a configurable ID, a pipelined read path with `readdatavalid`, a byte-writable scratch register, a capability word and an optional free-running 64-bit uptime counter with atomic high-word snapshot. Software uses it to confirm the loaded bitstream matches the compiled BSP and to timestamp events.

---
 rtl/lab9_soc_sysid_regs_if.sv | 12 +
 rtl/lab9_soc_sysid_regs.sv | 81 ++++++++
 tb/tb_lab9_soc_sysid_regs.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lab9_soc_sysid_regs_if.sv
// lab9_soc_sysid_regs_if: Avalon-MM slave bus bundle for the sysid register bank
interface lab9_soc_sysid_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  modport master (output address, read, write, byteenable, writedata, input readdata, readdatavalid);
  modport slave  (input address, read, write, byteenable, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/lab9_soc_sysid_regs.sv
// lab9_soc_sysid_regs: ID/timestamp/scratch/caps register bank with pipelined reads; uptime counter built when SYSID_UPTIME_EN is defined
module lab9_soc_sysid_regs #(
  parameter logic [31:0] SYSID_ID        = 32'd0,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1509475608,
  parameter int          READ_LATENCY    = 1,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input logic                   clock,
  input logic                   reset,
  lab9_soc_sysid_regs_if.slave  bus
);
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("lab9_soc_sysid_regs: READ_LATENCY must be 1..4");
  end
  logic        acc_rd;
  logic [31:0] rd_data;
  logic [31:0] scratch;
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0] dat_q [READ_LATENCY];
  // a simultaneous write wins; the read is dropped entirely
  assign acc_rd = bus.read & ~bus.write;
`ifdef SYSID_UPTIME_EN
  localparam logic CAP_UP = 1'b1;
  logic [63:0] uptime;
  logic [31:0] hi_snap;
  // free-running counter; a low-word read freezes the high word for a later atomic read
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime  <= '0;
      hi_snap <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      if (acc_rd && bus.address == 3'd3) hi_snap <= uptime[63:32];
    end
  end
  assign up_lo = uptime[31:0];
  assign up_hi = hi_snap;
`else
  localparam logic CAP_UP = 1'b0;
  assign up_lo = '0;
  assign up_hi = '0;
`endif
  // byte-lane writable scratch register
  always_ff @(posedge clock) begin
    if (reset) scratch <= SCRATCH_RESET;
    else if (bus.write && bus.address == 3'd2)
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
  end
  // read mux sampled in the acceptance cycle
  always_comb begin
    rd_data = '0;
    case (bus.address)
      3'd0: rd_data = SYSID_ID;
      3'd1: rd_data = SYSID_TIMESTAMP;
      3'd2: rd_data = scratch;
      3'd3: rd_data = up_lo;
      3'd4: rd_data = up_hi;
      3'd5: rd_data = {16'h5359, 7'd0, CAP_UP, 8'(READ_LATENCY)};
      default: rd_data = '0;
    endcase
  end
  // {valid, data} shift pipeline; data is zeroed when not valid so readdata idles at 0
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= acc_rd;
      dat_q[0] <= acc_rd ? rd_data : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end
  assign bus.readdatavalid = vld_q[READ_LATENCY-1];
  assign bus.readdata      = dat_q[READ_LATENCY-1];
endmodule

// File: tb/tb_lab9_soc_sysid_regs.sv
// tb_lab9_soc_sysid_regs: randomized + directed scoreboard bench for the sysid register bank
module tb_lab9_soc_sysid_regs;
  localparam int          L  = 3;
  localparam logic [31:0] ID = 32'hC0DE_0009;
  localparam logic [31:0] TS = 32'd1509475608;
  localparam logic [31:0] SR = 32'h5A5A_0F0F;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif
  typedef struct { logic [31:0] d; int t; int a; } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  lab9_soc_sysid_regs_if bus ();
  lab9_soc_sysid_regs #(
    .SYSID_ID(ID), .SYSID_TIMESTAMP(TS), .READ_LATENCY(L), .SCRATCH_RESET(SR)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] up = '0;
  logic [31:0] scratch_m = SR;
  logic [31:0] snap_m = '0;
  exp_t        q[$];
  // cycle index and uptime as seen by software: cycles elapsed since reset released
  always @(posedge clock) begin
    cyc <= cyc + 1;
    up  <= reset ? 64'd0 : up + 64'd1;
  end
  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return ID;
      3'd1: return TS;
      3'd2: return scratch_m;
      3'd3: return UP ? up[31:0] : 32'd0;
      3'd4: return UP ? snap_m : 32'd0;
      3'd5: return {16'h5359, 7'd0, UP, 8'(L)};
      default: return 32'd0;
    endcase
  endfunction
  task automatic drv(input bit rd, input bit wr, input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
    @(posedge clock); #1;
    bus.read = rd; bus.write = wr; bus.address = a; bus.byteenable = be; bus.writedata = wd;
    if (wr) begin
      if (a == 3'd2)
        for (int b = 0; b < 4; b++) if (be[b]) scratch_m[8*b +: 8] = wd[8*b +: 8];
    end else if (rd) begin
      q.push_back('{model_read(a), cyc, int'(a)});
      if (a == 3'd3 && UP) snap_m = up[63:32];
    end
  endtask
  task automatic rd(input logic [2:0] a);
    drv(1'b1, 1'b0, a, 4'h0, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 3'd0, 4'h0, 32'd0);
  endtask
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; bus.read = 1'b0; bus.write = 1'b0;
    scratch_m = SR; snap_m = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  // monitor: pops expectations on every response and checks data, latency and idle zeros
  always @(negedge clock) begin
    exp_t e;
    if (bus.readdatavalid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_rdv: readdata=%h at cycle %0d, required no response", bus.readdata, cyc);
      end else begin
        e = q.pop_front();
        if (bus.readdata !== e.d || cyc != e.t + L) begin
          errors++;
          $display("FAIL read_addr%0d: got %h at cycle %0d, required %h at cycle %0d", e.a, bus.readdata, cyc, e.d, e.t + L);
        end
      end
    end else begin
      checks++;
      if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'd0) begin
        errors++;
        $display("FAIL idle_outputs: rdv=%b readdata=%h, required rdv=0 readdata=0", bus.readdatavalid, bus.readdata);
      end
      if (q.size() != 0 && q[0].t + L <= cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rdv_addr%0d: no response at cycle %0d, required %h", e.a, cyc, e.d);
      end
    end
    if (reset) q.delete();
  end
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.byteenable = '0; bus.writedata = '0;
    do_reset();
    rd(3'd0); rd(3'd1); rd(3'd5); rd(3'd2);
    idle(L + 2);
    drv(1'b0, 1'b1, 3'd2, 4'hF, 32'hA5A5_A5A5);
    drv(1'b0, 1'b1, 3'd2, 4'h2, 32'h0000_3C00);
    rd(3'd2);
    drv(1'b0, 1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);
    drv(1'b0, 1'b1, 3'd5, 4'hF, 32'hFFFF_FFFF);
    rd(3'd0); rd(3'd5);
    drv(1'b1, 1'b1, 3'd2, 4'hF, 32'h1234_5678);
    idle(1);
    rd(3'd2);
    rd(3'd3); idle(2); rd(3'd4); rd(3'd6); rd(3'd7); rd(3'd3);
    idle(L + 2);
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)), $urandom);
    idle(L + 2);
`ifdef SYSID_UPTIME_EN
    @(posedge clock); #1;
    force dut.uptime = 64'h0000_0001_FFFF_FFFE;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 3'd3;
    q.push_back('{32'hFFFF_FFFE, cyc, 3});
    snap_m = 32'h0000_0001;
    @(posedge clock); #1;
    release dut.uptime;
    bus.read = 1'b0;
    idle(1);
    rd(3'd4);
    idle(L + 2);
`endif
    rd(3'd2);
    do_reset();
    idle(L + 3);
    rd(3'd2); rd(3'd3); rd(3'd4);
    idle(L + 3);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
